// File: rtl/data_ram_resp_pkg.sv
// Lane-mask constants shared by the data RAM response block, its storage and its users.
package data_ram_resp_pkg;

    localparam logic [3:0] LANE_WORD    = 4'hF;
    localparam logic [3:0] LANE_HALF_LO = 4'h3;
    localparam logic [3:0] LANE_HALF_HI = 4'hC;

endpackage

// File: rtl/data_ram_resp_if.sv
// Request/response bus between a requester and the data RAM response block.
interface data_ram_resp_if;

    logic [3:0]  da_ren;
    logic [31:0] da_addr;
    logic [3:0]  da_wen;
    logic [31:0] da_wdata;
    logic [31:0] da_rdata;
    logic        da_valid;

    modport master (
        output da_ren,
        output da_addr,
        output da_wen,
        output da_wdata,
        input  da_rdata,
        input  da_valid
    );

    modport slave (
        input  da_ren,
        input  da_addr,
        input  da_wen,
        input  da_wdata,
        output da_rdata,
        output da_valid
    );

endinterface

// File: rtl/data_ram_resp_dram_array.sv
// Single-port word array: byte-lane synchronous write, asynchronous read, no reset.
module dram_array
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            if (be == LANE_WORD) begin
                mem[addr] <= wdata;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_ram_resp.sv
// Fixed-latency read/write responder in front of a byte-lane word array.
// Requests are single-cycle pulses; a request that lands while busy is dropped and flagged.
//
//   state | meaning
//   IDLE  | no request outstanding; a nonzero da_ren/da_wen is accepted
//   WAIT  | request latched; counting down the remaining latency
//   RESP  | one-cycle da_valid; writes commit on the edge leaving this state
module data_ram_resp
    import data_ram_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                clk,
    input  logic                rstn,
    data_ram_resp_if.slave      bus,
    output logic                busy,
    output logic                err_overlap,
    output logic                err_range
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Accept edge plus LATENCY-2 WAIT cycles plus the RESP cycle spans LATENCY edges.
    localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            ren_q;
    logic [3:0]            wen_q;
    logic [31:0]           wdata_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  oor_q;

    logic                  req;
    logic                  accept;
    logic                  req_oor;
    logic                  is_write;
    logic                  mem_we;
    logic [31:0]           mem_rdata;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = {8{m[i]}};
        end
        return r;
    endfunction

    assign req     = (bus.da_ren != 4'd0) || (bus.da_wen != 4'd0);
    assign accept  = (state_q == IDLE) && req;
    assign req_oor = (bus.da_addr >> (DEPTH_LOG2 + 2)) != 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ren_q       <= 4'd0;
            wen_q       <= 4'd0;
            wdata_q     <= 32'd0;
            idx_q       <= '0;
            oor_q       <= 1'b0;
            err_overlap <= 1'b0;
            err_range   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                ren_q   <= bus.da_ren;
                wen_q   <= bus.da_wen;
                wdata_q <= bus.da_wdata;
                idx_q   <= bus.da_addr[DEPTH_LOG2+1:2];
                oor_q   <= req_oor;
                if (req_oor) begin
                    err_range <= 1'b1;
                end
            end
            if (req && (state_q != IDLE)) begin
                err_overlap <= 1'b1;
            end
        end
    end

    // A request with both enables set is a write; its read data stays zero.
    assign is_write = (wen_q != 4'd0);
    assign mem_we   = (state_q == RESP) && is_write && !oor_q;

    dram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .be    (wen_q),
        .addr  (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign busy         = (state_q != IDLE);
    assign bus.da_valid = (state_q == RESP);

    always_comb begin
        bus.da_rdata = 32'd0;
        if ((state_q == RESP) && !is_write && !oor_q) begin
            bus.da_rdata = mem_rdata & lane_bits(ren_q);
        end
    end

endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: directed vector table, corner sequences, randomized model check.
module tb_data_ram_resp;
    import data_ram_resp_pkg::*;

    localparam int L = 2;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    data_ram_resp_if bus();
    data_ram_resp_if bus1();

    logic busy, err_overlap, err_range;
    logic busy1, err_overlap1, err_range1;

    data_ram_resp #(.DEPTH_LOG2(10), .LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .bus(bus),
        .busy(busy), .err_overlap(err_overlap), .err_range(err_range)
    );

    data_ram_resp #(.DEPTH_LOG2(4), .LATENCY(1)) dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1),
        .busy(busy1), .err_overlap(err_overlap1), .err_range(err_range1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err_range;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask32(input logic [3:0] m);
        logic [31:0] r = 32'd0;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) r = r | (32'hFF << (8 * b));
        end
        return r;
    endfunction

    task automatic drive(input logic [3:0] ren, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus.da_ren   = ren;
        bus.da_wen   = wen;
        bus.da_addr  = addr;
        bus.da_wdata = wdata;
    endtask

    task automatic drive1(input logic [3:0] ren, input logic [3:0] wen,
                          input logic [31:0] addr, input logic [31:0] wdata);
        bus1.da_ren   = ren;
        bus1.da_wen   = wen;
        bus1.da_addr  = addr;
        bus1.da_wdata = wdata;
    endtask

    // One full transaction on the LATENCY=L instance, checking the response timing.
    task automatic txn(input string name, input logic [3:0] ren, input logic [3:0] wen,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata);
        @(negedge clk);
        drive(ren, wen, addr, wdata);
        @(negedge clk);
        drive(4'd0, 4'd0, 32'd0, 32'd0);
        check({name, " busy"}, 32'(busy), 32'd1);
        for (int k = 1; k < L; k++) begin
            check({name, " early valid"}, 32'(bus.da_valid), 32'd0);
            @(negedge clk);
        end
        check({name, " valid"}, 32'(bus.da_valid), 32'd1);
        check({name, " rdata"}, bus.da_rdata, exp_rdata);
        @(negedge clk);
        check({name, " valid drop"}, 32'(bus.da_valid), 32'd0);
        check({name, " rdata idle"}, bus.da_rdata, 32'd0);
        check({name, " busy idle"}, 32'(busy), 32'd0);
    endtask

    logic [31:0] m_mem [8];
    logic        m_err_ovl, m_err_rng;

    initial begin
        int pulses;

        rstn = 1'b0;
        drive(4'd0, 4'd0, 32'd0, 32'd0);
        drive1(4'd0, 4'd0, 32'd0, 32'd0);
        #1;
        check("rst valid", 32'(bus.da_valid), 32'd0);
        check("rst rdata", bus.da_rdata, 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst err_overlap", 32'(err_overlap), 32'd0);
        check("rst err_range", 32'(err_range), 32'd0);
        check("rst1 valid", 32'(bus1.da_valid), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        vecs[0]  = '{4'h0, LANE_WORD,    32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
        vecs[1]  = '{4'h0, LANE_WORD,    32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[2]  = '{LANE_WORD, 4'h0,    32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{4'h0, LANE_WORD,    32'h0000_0020, 32'h1122_3344, 32'h0000_0000, 1'b0};
        vecs[4]  = '{4'h0, LANE_HALF_HI, 32'h0000_0020, 32'hAABB_5566, 32'h0000_0000, 1'b0};
        vecs[5]  = '{LANE_WORD, 4'h0,    32'h0000_0020, 32'h0000_0000, 32'hAABB_3344, 1'b0};
        vecs[6]  = '{LANE_HALF_LO, 4'h0, 32'h0000_0020, 32'h0000_0000, 32'h0000_3344, 1'b0};
        vecs[7]  = '{LANE_HALF_HI, 4'h0, 32'h0000_0023, 32'h0000_0000, 32'hAABB_0000, 1'b0};
        vecs[8]  = '{LANE_WORD, LANE_HALF_LO, 32'h0000_0010, 32'h1234_CAFE, 32'h0000_0000, 1'b0};
        vecs[9]  = '{LANE_WORD, 4'h0,    32'h0000_0010, 32'h0000_0000, 32'hDEAD_CAFE, 1'b0};
        vecs[10] = '{4'h0, LANE_WORD,    32'h0000_1000, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[11] = '{LANE_WORD, 4'h0,    32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b1};
        vecs[12] = '{LANE_WORD, 4'h0,    32'h0000_1010, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[13] = '{4'h5, 4'h0,         32'h0000_0013, 32'h0000_0000, 32'h00AD_00FE, 1'b1};

        for (int v = 0; v < 14; v++) begin
            txn($sformatf("vec%0d", v), vecs[v].ren, vecs[v].wen, vecs[v].addr,
                vecs[v].wdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d err_range", v), 32'(err_range), 32'(vecs[v].exp_err_range));
        end
        check("table err_overlap", 32'(err_overlap), 32'd0);

        // Second request one cycle after the first is dropped.
        pulses = 0;
        @(negedge clk);
        drive(LANE_WORD, 4'h0, 32'h10, 32'h0);
        @(negedge clk);
        pulses += int'(bus.da_valid);
        drive(4'h0, LANE_WORD, 32'h10, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(4'd0, 4'd0, 32'd0, 32'd0);
        repeat (L + 3) begin
            pulses += int'(bus.da_valid);
            @(negedge clk);
        end
        check("overlap pulses", 32'(pulses), 32'd1);
        check("overlap err_overlap", 32'(err_overlap), 32'd1);
        txn("overlap readback", LANE_WORD, 4'h0, 32'h10, 32'h0, 32'hDEAD_CAFE);

        // Reset while the write sits in WAIT.
        @(negedge clk);
        drive(4'h0, LANE_WORD, 32'h10, 32'h0000_0000);
        @(negedge clk);
        drive(4'd0, 4'd0, 32'd0, 32'd0);
        rstn = 1'b0;
        #1;
        check("midrst valid", 32'(bus.da_valid), 32'd0);
        check("midrst rdata", bus.da_rdata, 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst err_overlap", 32'(err_overlap), 32'd0);
        check("midrst err_range", 32'(err_range), 32'd0);
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(bus.da_valid);
        end
        rstn = 1'b1;
        check("midrst no pulse", 32'(pulses), 32'd0);
        txn("midrst readback", LANE_WORD, 4'h0, 32'h10, 32'h0, 32'hDEAD_CAFE);

        // Randomized run against a transaction-level model.
        for (int w = 0; w < 8; w++) begin
            m_mem[w] = $urandom;
            txn($sformatf("init%0d", w), 4'h0, LANE_WORD, 32'(w * 4), m_mem[w], 32'd0);
        end
        m_err_ovl = err_overlap;
        m_err_rng = 1'b0;
        check("rand start err_overlap", 32'(err_overlap), 32'd0);
        begin
            bit          pend = 1'b0;
            int          resp_at = 0;
            logic [3:0]  p_ren = 4'd0, p_wen = 4'd0;
            logic [31:0] p_wdata = 32'd0;
            int          p_idx = 0;
            bit          p_oor = 1'b0;
            for (int i = 0; i < 600; i++) begin
                logic        exp_valid;
                logic [31:0] exp_rdata;
                @(negedge clk);
                exp_valid = pend && (i == resp_at);
                exp_rdata = 32'd0;
                if (exp_valid && p_wen == 4'd0 && !p_oor)
                    exp_rdata = m_mem[p_idx] & lane_mask32(p_ren);
                check($sformatf("rand%0d valid", i), 32'(bus.da_valid), 32'(exp_valid));
                check($sformatf("rand%0d rdata", i), bus.da_rdata, exp_rdata);
                check($sformatf("rand%0d busy", i), 32'(busy), 32'(pend));
                check($sformatf("rand%0d err_overlap", i), 32'(err_overlap), 32'(m_err_ovl));
                check($sformatf("rand%0d err_range", i), 32'(err_range), 32'(m_err_rng));
                drive(4'd0, 4'd0, 32'd0, 32'd0);
                if ($urandom_range(0, 2) == 0) begin
                    logic [3:0]  r_ren, r_wen;
                    logic [31:0] r_addr, r_wdata;
                    int          kind, r_idx;
                    kind    = $urandom_range(0, 3);
                    r_ren   = (kind == 1) ? 4'd0 : 4'($urandom_range(1, 15));
                    r_wen   = (kind == 1 || kind == 2) ? 4'($urandom_range(1, 15)) : 4'd0;
                    r_wdata = $urandom;
                    r_idx   = $urandom_range(0, 7);
                    if ($urandom_range(0, 9) == 0)
                        r_addr = (32'($urandom_range(1, 255)) << 12) | 32'(r_idx * 4);
                    else
                        r_addr = 32'(r_idx * 4 + $urandom_range(0, 3));
                    drive(r_ren, r_wen, r_addr, r_wdata);
                    if (pend) begin
                        m_err_ovl = 1'b1;
                    end else begin
                        pend    = 1'b1;
                        resp_at = i + L;
                        p_ren   = r_ren;
                        p_wen   = r_wen;
                        p_wdata = r_wdata;
                        p_idx   = r_idx;
                        p_oor   = (r_addr >= 32'h1000);
                        if (p_oor) m_err_rng = 1'b1;
                    end
                end
                if (exp_valid) begin
                    if (p_wen != 4'd0 && !p_oor) begin
                        for (int b = 0; b < 4; b++)
                            if (p_wen[b]) m_mem[p_idx][8*b +: 8] = p_wdata[8*b +: 8];
                    end
                    pend = 1'b0;
                end
            end
        end
        @(negedge clk);
        drive(4'd0, 4'd0, 32'd0, 32'd0);
        repeat (L + 2) @(negedge clk);

        // LATENCY=1 instance: response in the cycle after accept, request in that cycle dropped.
        check("l1 err_overlap start", 32'(err_overlap1), 32'd0);
        drive1(4'h0, LANE_WORD, 32'h8, 32'h1234_5678);
        @(negedge clk);
        check("l1 wr valid", 32'(bus1.da_valid), 32'd1);
        check("l1 wr rdata", bus1.da_rdata, 32'd0);
        check("l1 wr busy", 32'(busy1), 32'd1);
        drive1(4'h0, LANE_WORD, 32'h8, 32'hFFFF_FFFF);
        @(negedge clk);
        drive1(4'd0, 4'd0, 32'd0, 32'd0);
        check("l1 valid drop", 32'(bus1.da_valid), 32'd0);
        check("l1 busy idle", 32'(busy1), 32'd0);
        check("l1 err_overlap", 32'(err_overlap1), 32'd1);
        drive1(LANE_WORD, 4'h0, 32'h8, 32'h0);
        @(negedge clk);
        drive1(4'd0, 4'd0, 32'd0, 32'd0);
        check("l1 rd valid", 32'(bus1.da_valid), 32'd1);
        check("l1 rd rdata", bus1.da_rdata, 32'h1234_5678);
        @(negedge clk);
        check("l1 err_range pre", 32'(err_range1), 32'd0);
        drive1(4'h0, LANE_WORD, 32'h48, 32'h0);
        @(negedge clk);
        drive1(4'd0, 4'd0, 32'd0, 32'd0);
        check("l1 oor valid", 32'(bus1.da_valid), 32'd1);
        @(negedge clk);
        check("l1 err_range", 32'(err_range1), 32'd1);
        drive1(LANE_WORD, 4'h0, 32'h8, 32'h0);
        @(negedge clk);
        drive1(4'd0, 4'd0, 32'd0, 32'd0);
        check("l1 oor readback", bus1.da_rdata, 32'h1234_5678);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
